rr_select_encoder: RTL and testbench
====================================

# rr_select_encoder

Round-robin arbiter that drives the select/enable pair of the 2-to-4 one-hot decoder stage directly downstream. It takes four request lines, grants one at a time, and emits the winner as a 2-bit binary index `W` plus enable `En`. It holds each grant until the winner releases it or a hold timeout expires. Every grant change inserts one dead cycle with `En` low, so the decoder outputs are never two-hot and never switch directly between lines.

## Interface
- `HOLD_MAX`, default 16: maximum consecutive cycles a grant may be held; 0 disables the timeout.
- `Clock  in  1`: single clock; all state updates on the rising edge.
- `Reset  in  1`: synchronous, active-high; sampled on the rising edge of `Clock`.
- `req    in  4`: request lines; `req[i]` high means requester i wants the decoder line `y[i]`.
- `done   in  1`: release strobe from the current winner; only meaningful while `En` is high.
- `W      out 2`: registered grant index, fed to the decoder select.
- `En     out 1`: registered grant valid, fed to the decoder enable.
- `busy   out 1`: high in GRANT and RELEASE states.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: `En`=1, `W` stable.
  - RELEASE: one-cycle dead time, `En`=0.
- Priority pointer `ptr[1:0]` marks the highest-priority index.
- Search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4.
- IDLE → GRANT when `req` != 0:
  - `W` <= first set index in search order; `En` <= 1; hold counter <= 0.
- GRANT → RELEASE on any of the following:
  - `done`=1;
  - `req[W]`=0 (requester withdrew);
  - `HOLD_MAX`!=0 and counter = `HOLD_MAX`-1.
- On that transition:
  - `En` <= 0;
  - `ptr` <= `W`+1 (wraps 3 → 0);
  - `W` keeps its value.
- RELEASE → IDLE unconditionally.
- Otherwise in GRANT: counter increments, saturating at `HOLD_MAX`-1.
- Counter width is `$clog2(HOLD_MAX+1)`, minimum 1 bit.
- `req` bits other than `W` have no effect during GRANT or RELEASE.
- `done` outside GRANT is ignored.
- Reset, whether idle or mid-grant:
  - `W`=0, `En`=0, `busy`=0;
  - `ptr`=0, counter=0, state IDLE;
  - takes effect the cycle after it is sampled, overriding all other inputs.
- `W`/`En` never carry X after reset, so the decoder's X/Z fallback path is never exercised.

## Timing
- Grant latency:
  - `req` sampled high at edge N → `En`=1 and valid `W` after edge N (visible cycle N+1).
  - From IDLE, a grant can be sampled as early as the edge following the cycle in which `req` goes high.
- Release latency: `done` sampled at edge M → `En`=0 after edge M.
- Minimum gap between grants: `En` low for exactly 2 cycles (RELEASE, then IDLE) when requests are pending continuously.
- Re-grant after release of `W`=k: lands on edge M+2, using updated `ptr`=k+1.
- Timeout: with `done` never asserted and `req[W]` held, `En` is high for exactly `HOLD_MAX` cycles.
- `done` coinciding with the timeout cycle: a single release; no double pointer advance.
- Simultaneous `done` and `req[W]` drop: a single release.
- Outputs are pure register outputs; there is no combinational path from inputs to `W`, `En` or `busy`.

## Structure
- Shared package `rr_select_pkg`:
  - state encoding constants `S_IDLE`=2'd0, `S_GRANT`=2'd1, `S_RELEASE`=2'd2;
  - constant `N_REQ`=4.
- Sub-module `rr_pick`, combinational:
  - inputs `req[3:0]` and `ptr[1:0]`;
  - outputs `idx[1:0]` and `any`;
  - implements rotate, priority-encode, un-rotate.
- Top level holds the state register, pointer, hold counter and output registers.

## Test plan
- Reset then idle: assert `Reset` 2 cycles with `req`=4'b1111 → `W`=0, `En`=0, `busy`=0 throughout; first grant `W`=0 on the edge after `Reset` drops.
- Rotation: `req`=4'b1111 held, `done` pulsed 1 cycle after each grant → `W` sequence 0,1,2,3,0 with `En` low exactly 2 cycles between grants.
- Skip idle requesters: `ptr`=1 after granting 0, `req`=4'b1001 → next grant `W`=3, then `W`=0.
- Timeout: `HOLD_MAX`=4, `req`=4'b0100 held, no `done` → `En` high exactly 4 cycles with `W`=2, then 2 cycles low, then re-grant `W`=2.
- Withdraw and corner events:
  - `req[W]` dropped mid-grant → `En` low on the next edge;
  - `done` on the timeout cycle → single release, `ptr` advances by exactly 1.
- Reset mid-grant: `W`=3, `En`=1, assert `Reset` → next cycle `W`=0, `En`=0, `ptr`=0; with `req`=4'b1010 after release, first grant `W`=1.

Source files
------------

// File: rtl/rr_select_pkg.sv
// ---------------------------------------------------------------------------
// rr_select_pkg : shared types and constants for the round-robin select encoder
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rr_select_pkg;

  localparam int N_REQ = 4;
  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  // Hold counter must reach HOLD_MAX-1; never narrower than one bit.
  function automatic int cnt_width(input int hold_max);
    return (hold_max < 1) ? 1 : $clog2(hold_max + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick : combinational rotate / priority-encode / un-rotate search
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import rr_select_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [N_REQ-1:0] w_rot;
  logic [PTR_W-1:0] w_enc;

  always_comb begin
    w_rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_rot[i] = req[(i + int'(ptr)) % N_REQ];
    end
  end

  // Scan downward so the lowest rotated position (closest to ptr) wins.
  always_comb begin
    w_enc = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_enc = PTR_W'(i);
    end
  end

  assign idx = w_enc + ptr;
  assign any = |req;

endmodule

`default_nettype wire

// File: rtl/rr_select_encoder.sv
// ---------------------------------------------------------------------------
// rr_select_encoder : round-robin arbiter driving a 2-to-4 decoder select/enable
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_select_encoder
  import rr_select_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [PTR_W-1:0] W,
  output logic             En,
  output logic             busy
);

  localparam int               CW         = cnt_width(HOLD_MAX);
  localparam bit               TIMEOUT_EN = (HOLD_MAX != 0);
  localparam logic [CW-1:0]    CNT_LAST   = TIMEOUT_EN ? CW'(HOLD_MAX - 1) : '0;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0] W_q, W_d;
  logic             En_q, En_d;
  logic             busy_q, busy_d;

  logic [PTR_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic             w_timeout;
  logic             w_release;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  assign w_timeout = TIMEOUT_EN && (cnt_q == CNT_LAST);
  assign w_release = done || !req[W_q] || w_timeout;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    W_d     = W_q;
    En_d    = En_q;
    case (state_q)
      S_IDLE: begin
        if (w_pick_any) begin
          state_d = S_GRANT;
          W_d     = w_pick_idx;
          En_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      S_GRANT: begin
        // W is left untouched so the decoder select never moves while enabled.
        if (w_release) begin
          state_d = S_RELEASE;
          En_d    = 1'b0;
          ptr_d   = W_q + PTR_W'(1);
        end else if (TIMEOUT_EN && (cnt_q != CNT_LAST)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        En_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      W_q     <= '0;
      En_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      W_q     <= W_d;
      En_q    <= En_d;
      busy_q  <= busy_d;
    end
  end

  assign W    = W_q;
  assign En   = En_q;
  assign busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_select_encoder.sv
// ---------------------------------------------------------------------------
// tb_rr_select_encoder : directed and random checks against a behavioural model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rr_select_encoder;

  localparam int HM = 4;

  logic       Clock = 1'b0;
  logic       rst   = 1'b1;
  logic [3:0] req   = 4'b0000;
  logic       done  = 1'b0;
  logic [1:0] W;
  logic       En;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: who owns the decoder, dead-time flag, priority, hold age.
  bit m_en    = 0;
  bit m_dead  = 0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_held  = 0;

  rr_select_encoder #(.HOLD_MAX(HM)) dut (
    .Clock (Clock),
    .Reset (rst),
    .req   (req),
    .done  (done),
    .W     (W),
    .En    (En),
    .busy  (busy)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit finished;
    if (rst) begin
      m_en = 0; m_dead = 0; m_owner = 0; m_ptr = 0; m_held = 0;
    end else if (m_en) begin
      finished = done || !req[m_owner] || (HM != 0 && m_held == HM - 1);
      if (finished) begin
        m_en   = 0;
        m_dead = 1;
        m_ptr  = (m_owner + 1) % 4;
      end else if (m_held < HM - 1) begin
        m_held++;
      end
    end else if (m_dead) begin
      m_dead = 0;
    end else if (req != 4'b0000) begin
      for (int k = 3; k >= 0; k--) begin
        if (req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
      end
      m_en   = 1;
      m_held = 0;
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    model_step();
    #1;
    check("W", W, m_owner);
    check("En", En, m_en);
    check("busy", busy, m_en || m_dead);
  endtask

  initial begin
    int hi;

    // Reset held two cycles with every requester active
    rst = 1'b1; req = 4'b1111;
    tick(); check("rst_En", En, 0); check("rst_busy", busy, 0);
    tick(); check("rst_W", W, 0);   check("rst_En2", En, 0);
    rst = 1'b0;
    tick(); check("first_En", En, 1); check("first_W", W, 0);

    // Rotation through all four lines
    for (int g = 1; g <= 4; g++) begin
      done = 1'b1; tick(); check("rot_gap1", En, 0);
      done = 1'b0; tick(); check("rot_gap2", En, 0);
      tick(); check("rot_En", En, 1); check("rot_W", W, g % 4);
    end

    // Skip idle requesters
    req = 4'b1001;
    done = 1'b1; tick(); done = 1'b0; tick();
    tick(); check("skip_W3", W, 3); check("skip_En3", En, 1);
    done = 1'b1; tick(); done = 1'b0; tick();
    tick(); check("skip_W0", W, 0); check("skip_En0", En, 1);

    // Timeout with a single persistent requester
    req = 4'b0100;
    tick(); check("to_rel", En, 0);
    tick();
    tick(); check("to_En", En, 1); check("to_W", W, 2);
    hi = 1;
    for (int k = 0; k < 20 && En; k++) begin
      tick();
      if (En) hi++;
    end
    check("to_len", hi, HM);
    tick(); check("to_gap2", En, 0);
    tick(); check("to_regrant", En, 1); check("to_regrant_W", W, 2);

    // Requester withdraws mid-grant
    req = 4'b0000;
    tick(); check("withdraw", En, 0);
    tick();
    req = 4'b0100;
    tick(); check("wd_regrant", En, 1); check("wd_W", W, 2);

    // done coinciding with the timeout cycle: one release, pointer +1 only
    tick(); tick(); tick(); check("dto_still_on", En, 1);
    done = 1'b1; req = 4'b1111;
    tick(); check("dto_rel", En, 0);
    done = 1'b0;
    tick();
    tick(); check("dto_next_W", W, 3); check("dto_next_En", En, 1);

    // Reset while granted
    rst = 1'b1;
    tick(); check("mrst_W", W, 0); check("mrst_En", En, 0); check("mrst_busy", busy, 0);
    rst = 1'b0; req = 4'b1010;
    tick(); check("mrst_grant_W", W, 1); check("mrst_grant_En", En, 1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      req  = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 2) == 0);
      rst  = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
